// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and sizing helper for fifo_write_arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
    function automatic int level_width(input int id_width);
        return id_width + 3;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request bit at or above the pointer, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);
    // Descending scan so the smallest offset from the pointer wins; W-bit add wraps since N = 2**W.
    always_comb begin
        found_o = |req_i;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[ptr_i + W'(i)]) idx_o = ptr_i + W'(i);
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one sync FIFO write port,
// with a credit counter so it never writes into a full FIFO.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int p_REQUESTERS = 4,
    parameter int p_ID_WIDTH   = 2,
    parameter int p_DATA_WIDTH = 8,
    parameter int p_FIFO_DEPTH = 3,
    parameter int p_MAX_BURST  = 4
) (
    input  logic                                 i_CLK,
    input  logic                                 i_RESET,
    input  logic [p_REQUESTERS-1:0]              i_REQUEST,
    input  logic [p_REQUESTERS*p_DATA_WIDTH-1:0] i_DATA,
    input  logic [p_REQUESTERS-1:0]              i_LAST,
    input  logic                                 i_FIFO_READ,
    output logic [p_REQUESTERS-1:0]              o_ACCEPT,
    output logic                                 o_WRITE_REQUEST,
    output logic [p_DATA_WIDTH-1:0]              o_WRITE_DATA,
    output logic [p_ID_WIDTH-1:0]                o_WRITE_ID,
    output logic                                 o_BUSY,
    output logic [p_ID_WIDTH+2:0]                o_LEVEL,
    output logic                                 o_UNDERFLOW
);
    localparam int LW = level_width(p_ID_WIDTH);

    state_t                state_q;
    logic [p_ID_WIDTH-1:0] owner_q, rr_q, pick;
    logic [7:0]            cnt_q, cnt_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  found, can_write, own_req, accept, rd_hit, burst_end;

    rr_pick #(.N(p_REQUESTERS), .W(p_ID_WIDTH)) u_pick (
        .req_i   (i_REQUEST),
        .ptr_i   (rr_q),
        .found_o (found),
        .idx_o   (pick)
    );

    // Level counts at accept time, a cycle ahead of the FIFO write, so it never undercounts.
    always_comb begin
        can_write = level_q < LW'(p_FIFO_DEPTH);
        own_req = i_REQUEST[owner_q];
        accept = (state_q == BURST) && own_req && can_write;
        o_ACCEPT = accept ? (p_REQUESTERS'(1) << owner_q) : '0;
        cnt_d = cnt_q + 8'd1;
        burst_end = (state_q == BURST) && (!own_req || (accept && (i_LAST[owner_q] || cnt_d == 8'(p_MAX_BURST))));
        rd_hit = i_FIFO_READ && level_q != '0;
        level_d = level_q + LW'(accept) - LW'(rd_hit);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q <= IDLE;
            rr_q <= '0;
            owner_q <= '0;
            cnt_q <= '0;
            level_q <= '0;
            o_WRITE_REQUEST <= 1'b0;
            o_WRITE_DATA <= '0;
            o_WRITE_ID <= '0;
            o_UNDERFLOW <= 1'b0;
        end else begin
            level_q <= level_d;
            o_WRITE_REQUEST <= accept;
            if (i_FIFO_READ && level_q == '0) o_UNDERFLOW <= 1'b1;
            if (accept) begin
                o_WRITE_DATA <= i_DATA[owner_q*p_DATA_WIDTH +: p_DATA_WIDTH];
                o_WRITE_ID <= owner_q;
                cnt_q <= cnt_d;
            end
            if (state_q == IDLE && found) begin
                state_q <= BURST;
                owner_q <= pick;
                cnt_q <= '0;
            end else if (burst_end) begin
                state_q <= IDLE;
                rr_q <= owner_q + p_ID_WIDTH'(1);
            end
        end
    end

    assign o_BUSY = state_q == BURST;
    assign o_LEVEL = level_q;
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter that shares one sync FIFO write port between p_REQUESTERS producers.
- Grants bursts of up to p_MAX_BURST words to one producer at a time and muxes that producer's data onto the FIFO write port.
- Tracks FIFO occupancy with an internal credit counter fed by the consumer's read strobe, so it never writes into a full FIFO and never relies on the FIFO's registered status flags.
- Sits directly in front of the sync FIFO; the consumer drives the FIFO read side.

Parameters:
- p_REQUESTERS, 4, number of producers; power of two, 2..16.
- p_ID_WIDTH, 2, log2(p_REQUESTERS).
- p_DATA_WIDTH, 8, word width; must equal the FIFO data width.
- p_FIFO_DEPTH, 3, usable FIFO capacity in words; occupancy ceiling.
- p_MAX_BURST, 4, maximum words accepted per grant; 1..255.

Ports:
- i_CLK  in  1  clock.
- i_RESET  in  1  synchronous active-high reset.
- i_REQUEST  in  p_REQUESTERS  level; producer k holds a valid word.
- i_DATA  in  p_REQUESTERS*p_DATA_WIDTH  producer k word at [k*p_DATA_WIDTH +: p_DATA_WIDTH].
- i_LAST  in  p_REQUESTERS  producer k's current word ends its burst.
- i_FIFO_READ  in  1  consumer read strobe into the FIFO (same cycle the FIFO sees it).
- o_ACCEPT  out  p_REQUESTERS  combinational one-hot; word from producer k is taken this cycle.
- o_WRITE_REQUEST  out  1  registered FIFO write strobe.
- o_WRITE_DATA  out  p_DATA_WIDTH  registered FIFO write data.
- o_WRITE_ID  out  p_ID_WIDTH  registered source id of o_WRITE_DATA.
- o_BUSY  out  1  registered; a burst owner is latched.
- o_LEVEL  out  p_ID_WIDTH+3  registered committed occupancy, 0..p_FIFO_DEPTH.
- o_UNDERFLOW  out  1  sticky; i_FIFO_READ seen while level was 0.

Behaviour:
- Single clock, synchronous active-high reset on i_CLK.
- Reset state: IDLE, rr pointer 0, owner 0, burst count 0, level 0. Outputs reset to: o_WRITE_REQUEST 0, o_WRITE_DATA 0, o_WRITE_ID 0, o_BUSY 0, o_LEVEL 0, o_UNDERFLOW 0.
- Reset mid-burst abandons the burst immediately. The FIFO must be reset in the same cycle.
- Credit rule: can_write = (level < p_FIFO_DEPTH).
- State IDLE:
  - If any i_REQUEST bit is set, select the first set bit searching upward from the rr pointer, wrapping modulo p_REQUESTERS.
  - Latch it as owner, clear burst count, and go to BURST.
  - No accept happens in IDLE, so arbitration costs 1 cycle.
- State BURST:
  - accept = i_REQUEST[owner] & can_write.
  - o_ACCEPT[owner] = accept; all other o_ACCEPT bits are 0; all o_ACCEPT bits are 0 outside BURST.
  - On accept: o_WRITE_REQUEST<=1, o_WRITE_DATA<=i_DATA[owner], o_WRITE_ID<=owner, burst count +1. Write latency is 1 cycle after accept.
  - Otherwise o_WRITE_REQUEST<=0, and o_WRITE_DATA/o_WRITE_ID hold their values.
  - Burst ends on an accept with i_LAST[owner]=1, or on the accept that makes the count reach p_MAX_BURST.
  - Burst also ends when i_REQUEST[owner]=0 (producer withdraws; no accept).
  - At burst end: rr pointer <= owner+1 (wrapping), state <= IDLE. This gives a minimum 1-cycle gap between bursts.
  - If i_REQUEST[owner]=1 but can_write=0: stall in BURST with no accept. The grant is held (no preemption).
- Level update: next level = level + accept - (i_FIFO_READ & level!=0).
  - Simultaneous accept and read leave level unchanged.
  - A read at level 0 is ignored for the count and sets o_UNDERFLOW.
  - Level counts at accept, one cycle before the FIFO write lands, so it never undercounts.
- o_BUSY = 1 while in BURST.
- Requesters not granted must hold i_DATA/i_LAST stable until accepted.
- A producer may raise i_REQUEST in any cycle. Requests arriving during another producer's burst wait for IDLE.
- Throughput: one word per cycle within a burst while credits last.

Decomposition:
- Package fifo_arb_pkg holds the state encoding (IDLE=1'b0, BURST=1'b1) and a helper function for level width.
- Sub-module rr_pick (combinational): inputs request vector and rr pointer; outputs found flag and index (first set bit at or above the pointer, wrapping).
- The top level holds the FSM, burst counter, credit counter and output registers.

Test Plan:
- Reset then request=0001, data0=0xA5, last0=1 -> accept0 in cycle 2; write_req=1 with data=0xA5, id=0 in cycle 3; level=1; rr pointer=1.
- All four request continuously, last=0, p_MAX_BURST=4, consumer reads every cycle -> grants in order 0,1,2,3,0 with 4 words each; 1-cycle idle gap between bursts; level stays ≤1.
- Single producer, no reads, 5 words offered, depth 3 -> exactly 3 accepts, then stall with o_BUSY=1 and level=3; one i_FIFO_READ -> 4th accept next cycle, level back to 3.
- Accept and i_FIFO_READ in the same cycle at level=2 -> level stays 2.
- i_FIFO_READ at level 0 -> o_UNDERFLOW=1 and stays set until reset; level remains 0.
- i_RESET asserted mid-burst at level 2 -> next cycle all outputs at reset values, state IDLE, rr pointer 0, o_ACCEPT=0.
